// File: rtl/seq_shifter.sv
// rtl/seq_shifter.sv - iterative one-bit-per-clock shifter with start/done handshake
// Optional arithmetic right shift via SEQ_SHIFTER_ARITH_EN.
module seq_shifter #(
  parameter int WIDTH = 4,
  parameter int AMT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             dir,
  input  logic [WIDTH-1:0] a,
  input  logic [AMT_W-1:0] b,
`ifdef SEQ_SHIFTER_ARITH_EN
  input  logic             arith,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] sh_reg, sh_reg_n, result_n;
  logic [CNT_W-1:0] cnt, cnt_n, amt;
  logic             dir_q, dir_n, arith_q, arith_n, done_n;
  logic             arith_in, fill;

`ifdef SEQ_SHIFTER_ARITH_EN
  assign arith_in = arith;
`else
  assign arith_in = 1'b0;
`endif

  // The sign bit never moves during an arithmetic right shift, so it is the fill source.
  assign fill = arith_q & sh_reg[WIDTH-1];
  assign busy = (state == SHIFT);

  always_comb begin
    if (int'(b) >= WIDTH) amt = CNT_W'(WIDTH);
    else                  amt = CNT_W'(b);
  end

  always_comb begin
    state_n  = state;
    sh_reg_n = sh_reg;
    cnt_n    = cnt;
    dir_n    = dir_q;
    arith_n  = arith_q;
    result_n = result;
    done_n   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          sh_reg_n = a;
          cnt_n    = amt;
          dir_n    = dir;
          arith_n  = arith_in;
          state_n  = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt != '0) begin
          if (dir_q) sh_reg_n = {fill, sh_reg[WIDTH-1:1]};
          else       sh_reg_n = {sh_reg[WIDTH-2:0], 1'b0};
          cnt_n = cnt - CNT_W'(1);
        end else begin
          result_n = sh_reg;
          done_n   = 1'b1;
          state_n  = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      sh_reg  <= '0;
      cnt     <= '0;
      dir_q   <= 1'b0;
      arith_q <= 1'b0;
      result  <= '0;
      done    <= 1'b0;
    end else begin
      state   <= state_n;
      sh_reg  <= sh_reg_n;
      cnt     <= cnt_n;
      dir_q   <= dir_n;
      arith_q <= arith_n;
      result  <= result_n;
      done    <= done_n;
    end
  end

endmodule

// File: tb/tb_seq_shifter.sv
// tb/tb_seq_shifter.sv - directed self-checking bench for seq_shifter
// Arithmetic cases are exercised when SEQ_SHIFTER_ARITH_EN is defined.
module tb_seq_shifter;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         dir = 1'b0;
  logic         arith = 1'b0;
  logic [W-1:0] a = '0;
  logic [3:0]   b = '0;
  logic         busy, done;
  logic [W-1:0] result;

  int errors = 0;
  int checks = 0;
  int t = 0;

  // Reference model: an outstanding operation completes at a known edge with a known value.
  logic         m_pend = 1'b0;
  logic         m_done = 1'b0;
  logic [W-1:0] m_result = '0;
  logic [W-1:0] m_val = '0;
  int           m_due = 0;

  seq_shifter #(.WIDTH(W), .AMT_W(4)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .dir    (dir),
    .a      (a),
    .b      (b),
`ifdef SEQ_SHIFTER_ARITH_EN
    .arith  (arith),
`endif
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] shift_model(input logic [W-1:0] x, input int n,
                                               input logic d, input logic ar);
    logic [W-1:0] r;
    if (!d) begin
      r = x << n;
    end else begin
      r = x >> n;
`ifdef SEQ_SHIFTER_ARITH_EN
      if (ar) r = W'($signed(x) >>> n);
`endif
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, got, exp, t);
    end
  endtask

  task automatic cycle();
    int n;
    @(posedge clk);
    t++;
    if (!rst_n) begin
      m_pend   = 1'b0;
      m_done   = 1'b0;
      m_result = '0;
    end else begin
      m_done = 1'b0;
      if (!m_pend && start) begin
        n      = (int'(b) > W) ? W : int'(b);
        m_due  = t + n + 1;
        m_pend = 1'b1;
        m_val  = shift_model(a, n, dir, arith);
      end else if (m_pend && t == m_due) begin
        m_pend   = 1'b0;
        m_done   = 1'b1;
        m_result = m_val;
      end
    end
    #1;
    chk("busy", 32'(busy), 32'(m_pend));
    chk("done", 32'(done), 32'(m_done));
    chk("result", 32'(result), 32'(m_result));
  endtask

  // Launch one operation and compare latency/result against hand-computed literals.
  task automatic run_op(input string name, input logic [W-1:0] ia, input logic [3:0] ib,
                        input logic id, input logic iar, input logic [W-1:0] exp_r,
                        input int exp_lat);
    int  k;
    logic got;
    a = ia; b = ib; dir = id; arith = iar; start = 1'b1;
    cycle();
    start = 1'b0;
    chk({name, "_busy"}, 32'(busy), 32'd1);
    k = 0; got = 1'b0;
    while (!got && k < 40) begin
      cycle();
      k++;
      if (done === 1'b1) got = 1'b1;
    end
    chk({name, "_seen"}, 32'(got), 32'd1);
    chk({name, "_lat"}, 32'(k), 32'(exp_lat));
    chk({name, "_res"}, 32'(result), 32'(exp_r));
    chk({name, "_model"}, 32'(m_result), 32'(exp_r));
  endtask

  initial begin
    int k, ndone;
    logic got;

    rst_n = 1'b0;
    cycle();
    cycle();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    rst_n = 1'b1;
    cycle();

    run_op("t1_left",  4'b1101, 4'd2, 1'b0, 1'b0, 4'b0100, 3);
    run_op("t1_right", 4'b1101, 4'd2, 1'b1, 1'b0, 4'b0011, 3);
    run_op("t2_left",  4'b1001, 4'd1, 1'b0, 1'b0, 4'b0010, 2);
    run_op("t2_right", 4'b1001, 4'd1, 1'b1, 1'b0, 4'b0100, 2);
    run_op("t3_zero",  4'b1011, 4'd0, 1'b0, 1'b0, 4'b1011, 1);
    run_op("t3_clamp", 4'b1011, 4'd7, 1'b0, 1'b0, 4'b0000, 5);
    run_op("t3_clampr", 4'b1011, 4'd15, 1'b1, 1'b0, 4'b0000, 5);

    // Second start while busy must be ignored.
    a = 4'b1101; b = 4'd3; dir = 1'b0; start = 1'b1;
    cycle();
    a = 4'b0001; b = 4'd0; dir = 1'b1; start = 1'b1;
    cycle();
    start = 1'b0;
    k = 1; got = 1'b0;
    while (!got && k < 40) begin
      cycle();
      k++;
      if (done === 1'b1) got = 1'b1;
    end
    chk("t4_seen", 32'(got), 32'd1);
    chk("t4_lat", 32'(k), 32'd4);
    chk("t4_res", 32'(result), 32'(4'b1000));
    // Start in the done cycle: accepted with no gap.
    run_op("t4_b2b", 4'b1001, 4'd1, 1'b0, 1'b0, 4'b0010, 2);

    // Reset in the middle of a 4-bit shift.
    a = 4'b1111; b = 4'd4; dir = 1'b0; start = 1'b1;
    cycle();
    start = 1'b0;
    cycle();
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_done", 32'(done), 32'd0);
    chk("t5_result", 32'(result), 32'd0);
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      cycle();
      if (done === 1'b1) ndone++;
    end
    chk("t5_no_done", 32'(ndone), 32'd0);
    run_op("t5_after", 4'b1110, 4'd1, 1'b1, 1'b0, 4'b0111, 2);

`ifdef SEQ_SHIFTER_ARITH_EN
    run_op("t6_asr",    4'b1001, 4'd1,  1'b1, 1'b1, 4'b1100, 2);
    run_op("t6_lsr",    4'b1001, 4'd1,  1'b1, 1'b0, 4'b0100, 2);
    run_op("t6_clamp",  4'b1000, 4'd15, 1'b1, 1'b1, 4'b1111, 5);
    run_op("t6_lsl",    4'b1001, 4'd1,  1'b0, 1'b1, 4'b0010, 2);
`endif

    cycle();
    cycle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
